// File: rtl/pll_reset_sequencer.sv
// Qualifies a raw PLL lock flag and releases NUM_RESETS synchronous domain resets
// in index order, with lock-loss recovery, a saturating loss counter and soft re-sequence.
module pll_reset_sequencer #(
    parameter int unsigned NUM_RESETS         = 3,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGGER_CYCLES     = 16,
    parameter int unsigned CNT_W              = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_lock,
    input  logic                  soft_req,
    output logic [NUM_RESETS-1:0] resets,
    output logic                  ready,
    output logic [CNT_W-1:0]      lock_lost_count,
    output logic [1:0]            state
);

    if (NUM_RESETS < 1) begin : g_err_num_resets
        $error("NUM_RESETS must be >= 1");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_err_lock_stable
        $error("LOCK_STABLE_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_err_stagger
        $error("STAGGER_CYCLES must be >= 1");
    end

    localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned STAG_W = $clog2(STAGGER_CYCLES + 1);

    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAG_W-1:0]     STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [NUM_RESETS-1:0] ALL_ONES  = {NUM_RESETS{1'b1}};
    // Pattern with only resets[0] released.
    localparam logic [NUM_RESETS-1:0] FIRST_REL = ALL_ONES << 1;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StStable  = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, lock_s;
    logic [STAB_W-1:0]       stab_q, stab_d;
    logic [STAG_W-1:0]       stag_q, stag_d;
    logic [NUM_RESETS-1:0]   resets_q, resets_d;
    logic                    ready_q, ready_d;
    logic [CNT_W-1:0]        lost_q, lost_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s   <= 1'b0;
            state_q  <= StHold;
            stab_q   <= '0;
            stag_q   <= '0;
            resets_q <= ALL_ONES;
            ready_q  <= 1'b0;
            lost_q   <= '0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s   <= sync1_q;
            state_q  <= state_d;
            stab_q   <= stab_d;
            stag_q   <= stag_d;
            resets_q <= resets_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        stag_d   = stag_q;
        resets_d = resets_q;
        ready_d  = ready_q;
        lost_d   = lost_q;

        // Lock loss wins over soft_req; only losses after the first release are counted.
        if (state_q != StHold && (!lock_s || soft_req)) begin
            state_d  = StHold;
            stab_d   = '0;
            stag_d   = '0;
            resets_d = ALL_ONES;
            ready_d  = 1'b0;
            if (!lock_s && (state_q == StRelease || state_q == StRun) && lost_q != CNT_MAX) begin
                lost_d = lost_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                StHold: begin
                    stab_d   = '0;
                    stag_d   = '0;
                    resets_d = ALL_ONES;
                    ready_d  = 1'b0;
                    if (lock_s && !soft_req) begin
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_d  = StRelease;
                            resets_d = FIRST_REL;
                        end else begin
                            state_d = StStable;
                            stab_d  = STAB_W'(1);
                        end
                    end
                end
                StStable: begin
                    stab_d = stab_q + 1'b1;
                    if (stab_q == STAB_LAST) begin
                        state_d  = StRelease;
                        stag_d   = '0;
                        resets_d = FIRST_REL;
                    end
                end
                StRelease: begin
                    if (!resets_q[NUM_RESETS-1]) begin
                        state_d = StRun;
                        stag_d  = '0;
                        ready_d = 1'b1;
                    end else if (stag_q == STAG_LAST) begin
                        stag_d   = '0;
                        resets_d = resets_q << 1;
                    end else begin
                        stag_d = stag_q + 1'b1;
                    end
                end
                StRun: begin
                    resets_d = '0;
                    ready_d  = 1'b1;
                end
                default: state_d = StHold;
            endcase
        end
    end

    assign resets          = resets_q;
    assign ready           = ready_q;
    assign lock_lost_count = lost_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with NUM_RESETS=3, LOCK_STABLE_CYCLES=8,
// STAGGER_CYCLES=4, CNT_W=2; expected timing is indexed from E0 (first stage-1 capture of lock).
module tb_pll_reset_sequencer;

    localparam int N = 3;
    localparam int L = 8;
    localparam int S = 4;
    localparam int W = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         pll_lock;
    logic         soft_req;
    logic [N-1:0] resets;
    logic         ready;
    logic [W-1:0] lock_lost_count;
    logic [1:0]   state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    pll_reset_sequencer #(
        .NUM_RESETS        (N),
        .LOCK_STABLE_CYCLES(L),
        .STAGGER_CYCLES    (S),
        .CNT_W             (W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .soft_req       (soft_req),
        .resets         (resets),
        .ready          (ready),
        .lock_lost_count(lock_lost_count),
        .state          (state)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [N-1:0] r, input logic rdy,
                                 input logic [1:0] st);
        check_val({tag, ".resets"}, 32'(resets), 32'(r));
        check_val({tag, ".ready"}, 32'(ready), 32'(rdy));
        check_val({tag, ".state"}, 32'(state), 32'(st));
    endtask

    // Ticks edges E0+first .. E0+last, checking the qualified release timeline after each.
    task automatic run_seq(input int first, input int last);
        logic [N-1:0] r;
        logic [1:0]   st;
        for (int e = first; e <= last; e++) begin
            tick();
            for (int i = 0; i < N; i++) r[i] = (e >= 1 + L + i * S) ? 1'b0 : 1'b1;
            if (e < 2)                       st = 2'd0;
            else if (e < 1 + L)              st = 2'd1;
            else if (e < 2 + L + (N - 1) * S) st = 2'd2;
            else                             st = 2'd3;
            check_outputs($sformatf("seq e=%0d", e), r, (e >= 2 + L + (N - 1) * S), st);
            check_val($sformatf("seq.count e=%0d", e), 32'(lock_lost_count), 32'(exp_cnt));
        end
    endtask

    // One-cycle PLL dropout while in RUN, then a full relock.
    task automatic lose_lock_in_run();
        pll_lock = 1'b0;
        tick();
        check_val("loss.still_run", 32'(state), 32'd3);
        pll_lock = 1'b1;
        tick();
        check_outputs("loss.lock_s_low", '0, 1'b1, 2'd3);
        if (exp_cnt < 3) exp_cnt++;
        run_seq(1, 2 + L + (N - 1) * S);
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        soft_req = 1'b0;

        // Reset held for 3 cycles.
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outputs("reset", '1, 1'b0, 2'd0);
            check_val("reset.count", 32'(lock_lost_count), 32'd0);
        end
        reset = 1'b0;
        tick();
        check_outputs("idle_unlocked", '1, 1'b0, 2'd0);

        // First qualification and staggered release.
        pll_lock = 1'b1;
        run_seq(0, 2 + L + (N - 1) * S);

        // soft_req in RUN: full re-sequence, count unchanged.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        check_outputs("soft.hold", '1, 1'b0, 2'd0);
        run_seq(2, 2 + L + (N - 1) * S);

        // Glitch during STABLE: back to HOLD, uncounted, full requalification.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        tick();
        tick();
        tick();
        check_val("glitch.stable", 32'(state), 32'd1);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        check_val("glitch.stable5", 32'(state), 32'd1);
        run_seq(1, 2 + L + (N - 1) * S);

        // soft_req and lock loss on the same edge in RELEASE: counted.
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        pll_lock = 1'b0;
        tick();
        check_val("both.release", 32'(state), 32'd2);
        tick();
        check_outputs("both.release2", 3'b110, 1'b0, 2'd2);
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        exp_cnt = 1;
        check_outputs("both.hold", '1, 1'b0, 2'd0);
        check_val("both.count", 32'(lock_lost_count), 32'd1);

        // Reset asserted mid-RELEASE.
        pll_lock = 1'b1;
        run_seq(0, 1 + L + S);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        check_outputs("midreset", '1, 1'b0, 2'd0);
        check_val("midreset.count", 32'(lock_lost_count), 32'd0);
        run_seq(0, 2 + L + (N - 1) * S);

        // Four losses in RUN: count 1,2,3,3.
        for (int k = 0; k < 4; k++) begin
            lose_lock_in_run();
            check_val($sformatf("loss%0d.count", k), 32'(lock_lost_count), 32'(exp_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
